pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Consumer end of the branch-redirect interface: receives the taken-branch select and target from the branch unit and owns the architectural PC.
- Drives the instruction-memory fetch handshake.
- Holds a redirect that arrives while a fetch is outstanding.
- Generates the IF/ID flush pulse train that squashes wrong-path instructions.
- Sits at the front of the pipeline, between the branch unit (EX) and instruction memory.

Parameters:
- PC_W, 9, width of the PC and of the instruction-memory byte address.
- RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.
- FLUSH_CYC, 2, number of cycles flush stays high after a redirect is applied; range 1..7.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- PcSel  in  1  branch/jump taken, valid for one cycle.
- BrPC  in  32  redirect target; only bits [PC_W-1:0] are used.
- stall  in  1  hazard stall: hold PC, no new fetch.
- imem_ready  in  1  instruction memory accepts the current request this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_W  fetch address; equals Cur_PC.
- Cur_PC  out  PC_W  PC of the instruction in IF.
- flush  out  1  squash IF/ID contents.
- redirect_pend  out  1  a redirect is buffered and not yet applied.
- misalign_err  out  1  only present with the optional feature.

Behaviour:
- Reset, asynchronous, reset_n low:
  - Cur_PC=RESET_PC, imem_req=0, flush=0, redirect_pend=0, flush counter=0, state=BOOT.
  - Entering reset mid-operation discards any pending redirect and any flush in progress.
- State FETCH:
  - imem_req=1.
  - A fetch is "accepted" when imem_req && imem_ready && !stall.
  - imem_addr must stay stable while imem_req && !imem_ready.
- Next-PC priority, evaluated each cycle in FETCH:
  1. PcSel && (imem_ready || !imem_req): Cur_PC <= {BrPC[PC_W-1:2],2'b00}. Load the flush counter with FLUSH_CYC. This is applied even when stall=1; a redirect overrides a stall.
  2. PcSel && imem_req && !imem_ready: capture the target in the pend register, set redirect_pend=1, go to PEND. Cur_PC unchanged.
  3. Accepted fetch: Cur_PC <= Cur_PC+4, truncated to PC_W bits, so the all-ones-aligned PC wraps to 0.
  4. Otherwise hold.
- State PEND:
  - imem_req=1 and flush=1.
  - PcSel is ignored: the first redirect is the oldest and authoritative.
  - On imem_ready, load Cur_PC from the pend register, clear redirect_pend, load the flush counter, return to FETCH.
- State transitions:
  - BOOT→FETCH: first clock edge after reset_n goes high.
  - FETCH→PEND: case 2 above.
  - PEND→FETCH: imem_ready=1.
- Flush:
  - flush=1 in the cycle PcSel is sampled, while in PEND, and while the flush counter is nonzero.
  - The counter decrements each cycle and saturates at 0.
  - A new applied redirect while counting reloads FLUSH_CYC.
- Latency: PcSel at edge N makes the target visible on Cur_PC/imem_addr after edge N, provided imem_ready=1.
- BrPC bits above PC_W are ignored. Without the optional feature, bits [1:0] are forced to 0.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined, add output misalign_err:
  - If PcSel=1 and BrPC[1:0]!=0, the redirect is dropped: PC follows the normal priority, no flush.
  - misalign_err pulses high for exactly one cycle.
  - In PEND the check is applied when the target is captured.
- When not defined:
  - The port is absent.
  - A misaligned target is silently aligned down.

Test Plan:
- Reset with RESET_PC=0x010, imem_ready=1, stall=0 → imem_req=0 during reset; then Cur_PC=0x010, 0x014, 0x018 on successive cycles.
- PcSel=1, BrPC=0x0000_0040, imem_ready=1 at Cur_PC=0x018 → next cycle Cur_PC=0x040; flush high for the PcSel cycle plus 2 cycles; then increments resume (0x044, …).
- imem_ready=0 for 3 cycles with PcSel=1, BrPC=0x80 in the first of them, plus a second PcSel with BrPC=0x100 one cycle later → redirect_pend=1, imem_addr stable, second redirect ignored; when imem_ready=1 Cur_PC=0x080, redirect_pend=0.
- stall=1 held with PcSel=1, BrPC=0x0C0 → Cur_PC=0x0C0 despite the stall; it then holds until stall=0.
- Cur_PC=0x1FC (PC_W=9), accepted fetch → Cur_PC=0x000.
- MISALIGN_TRAP_EN defined, PcSel=1, BrPC=0x42 at Cur_PC=0x020 → misalign_err one-cycle pulse, Cur_PC=0x024, flush=0. Macro undefined → Cur_PC=0x040, flush asserted.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the PC, drives the imem fetch handshake, buffers redirects and flushes IF/ID.
// Optional MISALIGN_TRAP_EN drops misaligned redirect targets and pulses misalign_err.
module pc_fetch_ctrl #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            stall,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] Cur_PC,
  output logic            flush,
`ifdef MISALIGN_TRAP_EN
  output logic            misalign_err,
`endif
  output logic            redirect_pend
);
  typedef enum logic [1:0] {BOOT, FETCH, PEND} state_t;
  localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYC);
  state_t          r_state, w_state_nx;
  logic [PC_W-1:0] r_pc, w_pc_nx, r_pend, w_pend_nx;
  logic [2:0]      r_cnt, w_cnt_nx;
  logic            r_err, w_err_nx, w_req, w_flush, w_bad, w_sel;
  logic [PC_W-1:0] w_tgt;
  logic            w_unused_br;
  assign w_tgt       = {BrPC[PC_W-1:2], 2'b00};
  assign w_unused_br = ^BrPC[31:PC_W] ^ ^BrPC[1:0];
`ifdef MISALIGN_TRAP_EN
  assign w_bad = BrPC[1:0] != 2'b00;
`else
  assign w_bad = 1'b0;
`endif
  assign w_sel = PcSel && !w_bad;
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_pend_nx  = r_pend;
    w_cnt_nx   = r_cnt == 3'd0 ? 3'd0 : r_cnt - 3'd1;
    w_err_nx   = 1'b0;
    w_req      = 1'b0;
    w_flush    = r_cnt != 3'd0;
    case (r_state)
      BOOT: w_state_nx = FETCH;
      FETCH: begin
        w_req    = 1'b1;
        w_err_nx = PcSel && w_bad;
        if (w_sel && (imem_ready || !w_req)) begin
          w_pc_nx  = w_tgt;
          w_cnt_nx = FLUSH_LD;
          w_flush  = 1'b1;
        end else if (w_sel) begin
          w_pend_nx  = w_tgt;
          w_state_nx = PEND;
          w_flush    = 1'b1;
        end else if (imem_ready && !stall) begin
          w_pc_nx = r_pc + PC_W'(4);
        end
      end
      PEND: begin
        w_req   = 1'b1;
        w_flush = 1'b1;
        if (imem_ready) begin
          w_pc_nx    = r_pend;
          w_cnt_nx   = FLUSH_LD;
          w_state_nx = FETCH;
        end
      end
      default: w_state_nx = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_pend  <= '0;
      r_cnt   <= 3'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_pend  <= w_pend_nx;
      r_cnt   <= w_cnt_nx;
      r_err   <= w_err_nx;
    end
  end
  assign imem_req      = w_req;
  assign imem_addr     = r_pc;
  assign Cur_PC        = r_pc;
  assign flush         = w_flush;
  assign redirect_pend = r_state == PEND;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err  = r_err;
`else
  logic w_unused_err;
  assign w_unused_err = r_err;
`endif
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: table-driven scoreboard bench for pc_fetch_ctrl (RESET_PC=0x010, FLUSH_CYC=2).
module tb_pc_fetch_ctrl;
  localparam int PC_W = 9;
`ifdef MISALIGN_TRAP_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, PcSel = 1'b0, stall = 1'b0, imem_ready = 1'b1;
  logic [31:0] BrPC = '0;
  logic imem_req, flush, redirect_pend;
  logic [PC_W-1:0] imem_addr, Cur_PC;
`ifdef MISALIGN_TRAP_EN
  logic misalign_err;
`endif
  typedef struct {
    bit rn, ps, st, rdy;
    logic [31:0] br;
    bit req, fl, pd, er;
    logic [PC_W-1:0] pc;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t e;
  int errors = 0, checks = 0, vi = 0;
  always #5 clk = ~clk;
  pc_fetch_ctrl #(.PC_W(PC_W), .RESET_PC(9'h010), .FLUSH_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .PcSel(PcSel), .BrPC(BrPC), .stall(stall),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .Cur_PC(Cur_PC), .flush(flush),
`ifdef MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .redirect_pend(redirect_pend)
  );
  function automatic void add(bit rn, bit ps, logic [31:0] br, bit st, bit rdy,
                              bit req, logic [PC_W-1:0] pc, bit fl, bit pd, bit er);
    vec_t v;
    v.rn = rn; v.ps = ps; v.br = br; v.st = st; v.rdy = rdy;
    v.req = req; v.pc = pc; v.fl = fl; v.pd = pd; v.er = er;
    tbl.push_back(v);
  endfunction
  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, i, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("imem_req", vi, 32'(imem_req), 32'(e.req));
      chk("Cur_PC", vi, 32'(Cur_PC), 32'(e.pc));
      chk("imem_addr", vi, 32'(imem_addr), 32'(e.pc));
      chk("flush", vi, 32'(flush), 32'(e.fl));
      chk("redirect_pend", vi, 32'(redirect_pend), 32'(e.pd));
`ifdef MISALIGN_TRAP_EN
      chk("misalign_err", vi, 32'(misalign_err), 32'(e.er));
`endif
      vi++;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    add(0,0,32'h0,0,1, 0,9'h010,0,0,0);
    add(0,0,32'h0,0,1, 0,9'h010,0,0,0);
    add(1,0,32'h0,0,1, 0,9'h010,0,0,0);
    add(1,0,32'h0,0,1, 1,9'h010,0,0,0);
    add(1,0,32'h0,0,1, 1,9'h014,0,0,0);
    add(1,1,32'h40,0,1, 1,9'h018,1,0,0);
    add(1,0,32'h0,0,1, 1,9'h040,1,0,0);
    add(1,0,32'h0,0,1, 1,9'h044,1,0,0);
    add(1,0,32'h0,0,1, 1,9'h048,0,0,0);
    add(1,1,32'h80,0,0, 1,9'h04C,1,0,0);
    add(1,1,32'h100,0,0, 1,9'h04C,1,1,0);
    add(1,0,32'h0,0,0, 1,9'h04C,1,1,0);
    add(1,0,32'h0,0,1, 1,9'h04C,1,1,0);
    add(1,0,32'h0,0,1, 1,9'h080,1,0,0);
    add(1,0,32'h0,0,1, 1,9'h084,1,0,0);
    add(1,1,32'hC0,1,1, 1,9'h088,1,0,0);
    add(1,0,32'h0,1,1, 1,9'h0C0,1,0,0);
    add(1,0,32'h0,1,1, 1,9'h0C0,1,0,0);
    add(1,0,32'h0,1,1, 1,9'h0C0,0,0,0);
    add(1,0,32'h0,0,1, 1,9'h0C0,0,0,0);
    add(1,1,32'h1F8,0,1, 1,9'h0C4,1,0,0);
    add(1,0,32'h0,0,1, 1,9'h1F8,1,0,0);
    add(1,0,32'h0,0,1, 1,9'h1FC,1,0,0);
    add(1,1,32'h100,0,1, 1,9'h000,1,0,0);
    add(0,0,32'h0,0,1, 0,9'h010,0,0,0);
    add(1,0,32'h0,0,1, 0,9'h010,0,0,0);
    add(1,1,32'h80,0,0, 1,9'h010,1,0,0);
    add(1,0,32'h0,0,0, 1,9'h010,1,1,0);
    add(0,0,32'h0,0,0, 0,9'h010,0,0,0);
    add(1,0,32'h0,0,1, 0,9'h010,0,0,0);
    add(1,0,32'h0,0,1, 1,9'h010,0,0,0);
    add(1,1,32'h18,0,1, 1,9'h014,1,0,0);
    add(1,0,32'h0,0,1, 1,9'h018,1,0,0);
    add(1,0,32'h0,0,1, 1,9'h01C,1,0,0);
    add(1,1,32'hFFFF_FE42,0,1, 1,9'h020,!M,0,0);
    add(1,0,32'h0,0,1, 1,M ? 9'h024 : 9'h040,!M,0,M);
    add(1,0,32'h0,0,1, 1,M ? 9'h028 : 9'h044,!M,0,0);
    add(1,1,32'h81,0,0, 1,M ? 9'h02C : 9'h048,!M,0,0);
    add(1,0,32'h0,0,1, 1,M ? 9'h02C : 9'h048,!M,!M,M);
    add(1,0,32'h0,0,1, 1,M ? 9'h030 : 9'h080,!M,0,0);
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      reset_n = tbl[i].rn;
      PcSel = tbl[i].ps;
      BrPC = tbl[i].br;
      stall = tbl[i].st;
      imem_ready = tbl[i].rdy;
      sb.push_back(tbl[i]);
    end
    @(posedge clk);
    #1;
    PcSel = 1'b0;
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", vi, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
